// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared types and default widths for the fetch buffer
package fetch_buffer_pkg;

    localparam int PADDR_WIDTH      = 32;
    localparam int FETCH_WIDTH_DEF  = 4;
    localparam int DECODE_WIDTH_DEF = 2;
    localparam int DEPTH_DEF        = 16;

    typedef struct packed {
        logic                   valid;
        logic [PADDR_WIDTH-1:0] pc;
        logic [31:0]            instr;
    } fetched_instr_t;

endpackage

// File: rtl/fetch_compact.sv
// rtl/fetch_compact.sv - prefix popcount giving per-lane write offsets and total enqueue count
module fetch_compact #(
    parameter int FETCH_WIDTH = 4,
    parameter int CNT_W       = 5
) (
    input  logic [FETCH_WIDTH-1:0]            valid_i,
    output logic [FETCH_WIDTH-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]                  nenq_o
);

    logic [CNT_W-1:0] run;

    // Each lane's offset is the number of valid lanes below it; the final sum is nenq.
    always_comb begin
        run = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            offset_o[k] = run;
            run         = run + CNT_W'(valid_i[k]);
        end
        nenq_o = run;
    end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order circular instruction queue between fetch and decode
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH  = FETCH_WIDTH_DEF,
    parameter int DECODE_WIDTH = DECODE_WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  fetched_instr_t [0:FETCH_WIDTH-1]    i_instrs,
    output logic                                o_fetch_ready,
    input  logic                                i_flush,
    output fetched_instr_t [0:DECODE_WIDTH-1]   o_instrs,
    input  logic                                i_dec_ready,
    output logic [$clog2(DEPTH):0]              o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetched_instr_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [FETCH_WIDTH-1:0]            lane_valid;
    logic [FETCH_WIDTH-1:0][CNT_W-1:0] lane_off;
    logic [CNT_W-1:0]                  nenq;
    logic [CNT_W-1:0]                  nenq_eff;
    logic [CNT_W-1:0]                  ndeq;
    logic                              enq_fire;
    logic [PTR_W-1:0]                  occ_wrap;

    // Gather the per-lane valid bits for the compaction network.
    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            lane_valid[k] = i_instrs[k].valid;
        end
    end

    fetch_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .CNT_W       (CNT_W)
    ) u_compact (
        .valid_i  (lane_valid),
        .offset_o (lane_off),
        .nenq_o   (nenq)
    );

    // Ready depends only on registered occupancy; a same-cycle drain is not credited.
    assign o_fetch_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
    assign enq_fire      = o_fetch_ready & ~i_flush;
    assign nenq_eff      = enq_fire ? nenq : '0;
    assign o_count       = count_q;

    // Decode takes every presented valid lane or none.
    always_comb begin
        ndeq = '0;
        if (i_dec_ready) begin
            ndeq = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
        end
    end

    // Pointer and occupancy next state; flush overrides everything.
    always_comb begin
        head_d  = head_q + PTR_W'(ndeq);
        tail_d  = tail_q + PTR_W'(nenq_eff);
        count_d = count_q + nenq_eff - ndeq;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write: valid lanes land in consecutive free slots starting at tail.
    always_ff @(posedge i_clk) begin
        if (enq_fire) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (lane_valid[k]) begin
                    mem_q[tail_q + PTR_W'(lane_off[k])] <= i_instrs[k];
                end
            end
        end
    end

    // Output window: oldest entries from head, valid masked by occupancy.
    always_comb begin
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            o_instrs[k]       = mem_q[head_q + PTR_W'(k)];
            o_instrs[k].valid = CNT_W'(k) < count_q;
        end
    end

    assign occ_wrap = tail_q - head_q;

    a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        count_q <= CNT_W'(DEPTH));

    a_count_ptrs: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (count_q == CNT_W'(DEPTH)) ? (occ_wrap == '0) : (CNT_W'(occ_wrap) == count_q));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized and directed self-checking bench for fetch_buffer
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int FW    = 4;
    localparam int DW    = 2;
    localparam int DEPTH = 16;

    logic                      i_clk;
    logic                      i_rst_n;
    fetched_instr_t [0:FW-1]   i_instrs;
    logic                      o_fetch_ready;
    logic                      i_flush;
    fetched_instr_t [0:DW-1]   o_instrs;
    logic                      i_dec_ready;
    logic [4:0]                o_count;

    fetch_buffer #(
        .FETCH_WIDTH  (FW),
        .DECODE_WIDTH (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_instrs      (i_instrs),
        .o_fetch_ready (o_fetch_ready),
        .i_flush       (i_flush),
        .o_instrs      (o_instrs),
        .i_dec_ready   (i_dec_ready),
        .o_count       (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    fetched_instr_t model_q [$];
    logic [31:0] pc_seq;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = model_q.size();
        expect_eq("count", 64'(o_count), 64'(sz));
        expect_eq("fetch_ready", 64'(o_fetch_ready), 64'((DEPTH - sz) >= FW));
        for (int k = 0; k < DW; k++) begin
            expect_eq("out_valid", 64'(o_instrs[k].valid), 64'(k < sz));
            if (k < sz) begin
                expect_eq("out_pc", 64'(o_instrs[k].pc), 64'(model_q[k].pc));
                expect_eq("out_instr", 64'(o_instrs[k].instr), 64'(model_q[k].instr));
            end
        end
    endtask

    // Called at a negedge: apply one cycle of stimulus, advance the model, check after the edge.
    task automatic step(input logic [FW-1:0] mask, input logic dec, input logic fl);
        bit rdy;
        int nd;
        rdy = (DEPTH - model_q.size()) >= FW;
        for (int k = 0; k < FW; k++) begin
            i_instrs[k].valid = mask[k];
            i_instrs[k].pc    = pc_seq;
            i_instrs[k].instr = $urandom;
            pc_seq            = pc_seq + 32'd4;
        end
        i_dec_ready = dec;
        i_flush     = fl;
        nd = dec ? ((model_q.size() < DW) ? model_q.size() : DW) : 0;
        for (int j = 0; j < nd; j++) void'(model_q.pop_front());
        if (fl) model_q.delete();
        else if (rdy) begin
            for (int k = 0; k < FW; k++) if (mask[k]) model_q.push_back(i_instrs[k]);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_model();
    endtask

    task automatic apply_reset();
        i_rst_n     = 1'b0;
        i_flush     = 1'b0;
        i_dec_ready = 1'b0;
        for (int k = 0; k < FW; k++) i_instrs[k] = '0;
        model_q.delete();
        #1;
        expect_eq("rst_count", 64'(o_count), 64'd0);
        expect_eq("rst_ready", 64'(o_fetch_ready), 64'd1);
        expect_eq("rst_v0", 64'(o_instrs[0].valid), 64'd0);
        expect_eq("rst_v1", 64'(o_instrs[1].valid), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        pc_seq = 32'h0;
        apply_reset();

        // Basic flow
        pc_seq = 32'h100;
        step(4'b1111, 1'b0, 1'b0);
        expect_eq("basic_count", 64'(o_count), 64'd4);
        expect_eq("basic_pc0", 64'(o_instrs[0].pc), 64'h100);
        expect_eq("basic_pc1", 64'(o_instrs[1].pc), 64'h104);
        expect_eq("basic_v1", 64'(o_instrs[1].valid), 64'd1);

        // Compaction into an empty buffer
        apply_reset();
        pc_seq = 32'h200;
        step(4'b1010, 1'b0, 1'b0);
        expect_eq("cmp_pc0", 64'(o_instrs[0].pc), 64'h204);
        expect_eq("cmp_pc1", 64'(o_instrs[1].pc), 64'h20C);
        expect_eq("cmp_count", 64'(o_count), 64'd2);

        // Backpressure up to full, then a dropped group
        apply_reset();
        pc_seq = 32'h1000;
        for (int g = 0; g < 3; g++) step(4'b1111, 1'b0, 1'b0);
        expect_eq("full12_count", 64'(o_count), 64'd12);
        expect_eq("full12_ready", 64'(o_fetch_ready), 64'd1);
        step(4'b1111, 1'b0, 1'b0);
        expect_eq("full16_count", 64'(o_count), 64'd16);
        expect_eq("full16_ready", 64'(o_fetch_ready), 64'd0);
        step(4'b1111, 1'b0, 1'b0);
        expect_eq("drop_count", 64'(o_count), 64'd16);

        // Drain to head=14, count=2, then enqueue and dequeue together across the wrap
        for (int d = 0; d < 7; d++) step(4'b0000, 1'b1, 1'b0);
        expect_eq("pre_wrap_count", 64'(o_count), 64'd2);
        pc_seq = 32'h2000;
        step(4'b1111, 1'b1, 1'b0);
        expect_eq("wrap_count", 64'(o_count), 64'd4);
        expect_eq("wrap_pc0", 64'(o_instrs[0].pc), 64'h2000);
        expect_eq("wrap_pc1", 64'(o_instrs[1].pc), 64'h2004);
        step(4'b0000, 1'b1, 1'b0);
        expect_eq("wrap_pc2", 64'(o_instrs[0].pc), 64'h2008);

        // Flush with a concurrent enqueue and dequeue
        apply_reset();
        pc_seq = 32'h3000;
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        expect_eq("pre_flush_count", 64'(o_count), 64'd10);
        step(4'b1111, 1'b1, 1'b1);
        expect_eq("flush_count", 64'(o_count), 64'd0);
        expect_eq("flush_v0", 64'(o_instrs[0].valid), 64'd0);
        expect_eq("flush_ready", 64'(o_fetch_ready), 64'd1);
        pc_seq = 32'h3800;
        step(4'b0001, 1'b0, 1'b0);
        expect_eq("post_flush_pc", 64'(o_instrs[0].pc), 64'h3800);

        // Asynchronous reset in the middle of a cycle
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        expect_eq("pre_arst_count", 64'(o_count), 64'd7);
        #2;
        i_rst_n = 1'b0;
        #1;
        expect_eq("arst_count", 64'(o_count), 64'd0);
        expect_eq("arst_v0", 64'(o_instrs[0].valid), 64'd0);
        expect_eq("arst_v1", 64'(o_instrs[1].valid), 64'd0);
        model_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pc_seq = 32'h4000;
        step(4'b0110, 1'b0, 1'b0);
        expect_eq("arst_resume_pc", 64'(o_instrs[0].pc), 64'h4004);

        // Randomized traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            step(4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
